coax_rx_controller: RTL

//  Sequences the Type A coax receiver and turns its word stream into framed messages.
//  - Gates the receiver enable around transmit turnaround.
//  - Stages each word so that the last word of a frame can be tagged.
//  - Checks parity and buffers tagged words in a FIFO for the protocol layer.
//  - Sits between the coax receiver and the command decoder / host interface.

---
 rtl/coax_rx_controller.sv | 112 +++++++++++
 1 files changed

// File: rtl/coax_rx_controller.sv
// coax_rx_controller: Type A coax receive sequencer, staging and message FIFO; define PARITY_CHECK_EN for parity checking
module coax_rx_controller #(
    parameter int FIFO_AW     = 4,
    parameter int HOLDOFF_CYC = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_active,
    input  logic [11:0]      rx_word,
    input  logic             rx_word_valid,
    output logic             rx_enable,
    input  logic             tx_busy,
    output logic [13:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clear_status,
    output logic             overflow,
    output logic             perr_seen,
    output logic [CNT_W-1:0] frame_count
);
    localparam int CW = $clog2(HOLDOFF_CYC + 2);
    localparam int PW = FIFO_AW + 1;
    typedef enum logic [1:0] {IDLE, RECV, TX, HOLDOFF} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic stg_full, stg_full_n, push, last, perr, pop, full, wr;
    logic [11:0] stg_word, stg_word_n;
    logic [PW-1:0] wp, rp;
    logic [13:0] mem [2**FIFO_AW];

    always_comb begin
        state_n = state;
        stg_full_n = stg_full;
        stg_word_n = stg_word;
        push = 1'b0;
        last = 1'b0;
        case (state)
            IDLE: state_n = rx_active ? RECV : tx_busy ? TX : IDLE;
            RECV: begin
                if (rx_word_valid) begin
                    push = stg_full;
                    stg_full_n = 1'b1;
                    stg_word_n = rx_word;
                end else if (!rx_active || tx_busy) begin
                    push = stg_full;
                    last = 1'b1;
                    stg_full_n = 1'b0;
                    state_n = tx_busy ? TX : IDLE;
                end
            end
            TX: state_n = tx_busy ? TX : HOLDOFF;
            default: state_n = tx_busy ? TX : (cnt <= CW'(1)) ? IDLE : HOLDOFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HOLDOFF;
            cnt <= CW'(HOLDOFF_CYC);
            stg_full <= 1'b0;
            stg_word <= '0;
            rx_enable <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= (state == HOLDOFF) ? cnt - CW'(1) : CW'(HOLDOFF_CYC);
            stg_full <= stg_full_n;
            stg_word <= stg_word_n;
            rx_enable <= (state == IDLE) || (state == RECV);
        end
    end

`ifdef PARITY_CHECK_EN
    assign perr = ^stg_word;
    always_ff @(posedge clk) begin
        if (reset)
            perr_seen <= 1'b0;
        else if (wr && perr)
            perr_seen <= 1'b1;
        else if (clear_status)
            perr_seen <= 1'b0;
    end
`else
    assign perr = 1'b0;
    assign perr_seen = 1'b0;
`endif

    assign out_valid = wp != rp;
    assign pop = out_valid && out_ready;
    assign full = (wp[FIFO_AW] != rp[FIFO_AW]) && (wp[FIFO_AW-1:0] == rp[FIFO_AW-1:0]);
    assign wr = push && (!full || pop);
    assign out_data = mem[rp[FIFO_AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr)
            mem[wp[FIFO_AW-1:0]] <= {last, perr, stg_word};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
            overflow <= 1'b0;
            frame_count <= '0;
        end else begin
            wp <= wp + PW'(wr);
            rp <= rp + PW'(pop);
            overflow <= (push && !wr) ? 1'b1 : clear_status ? 1'b0 : overflow;
            frame_count <= frame_count + CNT_W'(push && last);
        end
    end
endmodule
